missile_hit_ctl: RTL
====================

# missile_hit_ctl

Collision and player-life controller that consumes the five enemy missile positions produced by the enemy group (`en1..en5_x/y_missile`) together with the player ship position. Once per frame it snapshots all positions, scans the five missiles sequentially against the ship bounding box, and decrements the player life count on a hit. After a hit it applies a frame-counted invulnerability window, and it flags game over when lives reach zero. It sits downstream of the enemy group and feeds the HUD/game-state logic.

## Interface
Parameters:
- `SHIP_W`, 64, ship bounding-box width in pixels
- `SHIP_H`, 48, ship bounding-box height in pixels
- `MIS_W`, 4, enemy missile width in pixels
- `MIS_H`, 12, enemy missile height in pixels
- `Y_LIMIT`, 768, missile with `y >= Y_LIMIT` is inactive (off-screen)
- `LIVES_INIT`, 3, lives loaded at reset and on `new_game`
- `INVULN_FRAMES`, 120, frames of invulnerability after a hit

Ports:
- `pclk`  in  1  pixel clock; the only clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `vsync_in`  in  1  vertical sync; its rising edge marks a frame
- `xpos_ship`, `ypos_ship`  in  11 each  ship top-left position
- `en1_x_missile` … `en5_x_missile`  in  11 each  missile top-left x
- `en1_y_missile` … `en5_y_missile`  in  11 each  missile top-left y
- `new_game`  in  1  single-cycle restart pulse
- `lives`  out  3  remaining lives
- `hit`  out  1  single-cycle pulse on each accepted hit
- `invuln`  out  1  high while the invulnerability counter is nonzero
- `game_over`  out  1  high from the moment lives reach 0 until `new_game`

## Operation
- `vsync_d` is `vsync_in` registered. A frame edge is `vsync_in & ~vsync_d`.
- FSM states: IDLE, SCAN, RESOLVE, DEAD.
  - IDLE: on a frame edge, latch the ship x/y and all 10 missile coordinates into snapshot registers, clear `hit_flag`, set `idx` to 0, and go to SCAN.
  - SCAN: test snapshot missile `idx`.
    - `hit_flag |= active && overlap`, where `active = (y < Y_LIMIT)`.
    - `overlap = (mx+MIS_W > sx) && (mx < sx+SHIP_W) && (my+MIS_H > sy) && (my < sy+SHIP_H)`.
    - All sums are evaluated in 12 bits, so there is no wrap.
    - `idx` increments each cycle. After `idx == 4`, go to RESOLVE.
  - RESOLVE, exactly one cycle:
    - If `hit_flag && invuln_cnt == 0 && lives != 0`: `lives <= lives-1`, `hit <= 1`, `invuln_cnt <= INVULN_FRAMES`. If `lives == 1`, set `game_over <= 1` and go to DEAD; otherwise go to IDLE.
    - Otherwise: if `invuln_cnt != 0`, `invuln_cnt <= invuln_cnt-1`. Go to IDLE.
  - DEAD: ignore frame edges. `lives`, `game_over` and `invuln_cnt` are held.
- `new_game` has priority in every state. On the next edge: `lives <= LIVES_INIT`, `invuln_cnt <= 0`, `game_over <= 0`, `hit <= 0`, state IDLE. A scan in progress is discarded.
- Several missiles hitting in one frame count as one hit; at most one life is lost per frame.
- Frame edges arriving while in SCAN or RESOLVE are ignored; the next frame is taken on the following edge.
- `invuln = (invuln_cnt != 0)`, registered. `invuln_cnt` is 8 bits, so `INVULN_FRAMES` must be ≤ 255.
- `hit` defaults to 0 on every cycle that is not a RESOLVE-accepted hit.

## Timing
- Reset values: state IDLE, `lives = LIVES_INIT`, `hit = 0`, `invuln = 0`, `game_over = 0`, `invuln_cnt = 0`, `vsync_d = 0`, snapshot registers = 0.
- Cycle numbering, with the frame edge at cycle E (IDLE, `vsync_in=1`, `vsync_d=0`):
  - E+1 … E+5: SCAN.
  - E+6: RESOLVE.
  - E+7: `hit`, `lives`, `invuln` and `game_over` show the new values. Edge-to-output latency is 7 clocks.
- The invulnerability counter decrements once per frame, in RESOLVE. The frame whose RESOLVE accepts a hit does not decrement.
- Input changes after cycle E do not affect that frame's result.
- `new_game` takes effect on the next clock; outputs update one cycle later.

## Test plan
- Ship at (400,600), missile 3 at (420,610), others at y=800, `vsync_in` rising edge → `hit`=1 for exactly one cycle at E+7; `lives` 3→2; `invuln`=1.
- Same overlap held for 3 consecutive frames → only the first frame decrements (`lives`=2). `invuln` clears after 120 further frames, then the next overlap frame gives `lives`=1.
- Edge cases on ship at (100,100):
  - Missile at (164,100) → no hit (`mx == sx+SHIP_W`).
  - Missile at (163,100) → hit.
  - Missile at (100,800) → no hit (inactive).
- All five missiles overlapping in one frame → exactly one `hit` pulse, `lives` decremented by 1.
- Run lives down from 1 to 0 → `game_over`=1 at E+7. Further overlapping frames → no `hit`, `lives` stays 0. `new_game` → `lives`=3 and `game_over`=0 one cycle later.
- Assert `rst`=0 mid-SCAN → outputs return to reset values immediately (asynchronously). After release, the next frame edge scans normally.

Source files
------------

// File: rtl/missile_hit_ctl.sv
// Per-frame enemy-missile vs. player-ship collision check with life counting,
// post-hit invulnerability window and game-over latch.
module missile_hit_ctl #(
    parameter int unsigned SHIP_W        = 64,
    parameter int unsigned SHIP_H        = 48,
    parameter int unsigned MIS_W         = 4,
    parameter int unsigned MIS_H         = 12,
    parameter int unsigned Y_LIMIT       = 768,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned INVULN_FRAMES = 120
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic [10:0] xpos_ship,
    input  logic [10:0] ypos_ship,
    input  logic [10:0] en1_x_missile,
    input  logic [10:0] en2_x_missile,
    input  logic [10:0] en3_x_missile,
    input  logic [10:0] en4_x_missile,
    input  logic [10:0] en5_x_missile,
    input  logic [10:0] en1_y_missile,
    input  logic [10:0] en2_y_missile,
    input  logic [10:0] en3_y_missile,
    input  logic [10:0] en4_y_missile,
    input  logic [10:0] en5_y_missile,
    input  logic        new_game,
    output logic [2:0]  lives,
    output logic        hit,
    output logic        invuln,
    output logic        game_over
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned N_MIS = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE, S_DEAD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_vsync_d;
    logic               w_frame_edge;
    logic [POS_W-1:0]   r_sx;
    logic [POS_W-1:0]   r_sy;
    logic [POS_W-1:0]   r_mx [N_MIS];
    logic [POS_W-1:0]   r_my [N_MIS];
    logic [2:0]         r_idx;
    logic               r_hit_flag;
    logic [CNT_W-1:0]   r_invuln_cnt;
    logic [2:0]         r_lives;
    logic               r_hit;
    logic               r_invuln;
    logic               r_game_over;

    logic [SUM_W-1:0]   w_mx;
    logic [SUM_W-1:0]   w_my;
    logic [SUM_W-1:0]   w_sx;
    logic [SUM_W-1:0]   w_sy;
    logic               w_active;
    logic               w_overlap;
    logic               w_mis_hit;
    logic               w_accept;

    logic [2:0]         w_lives_nxt;
    logic               w_hit_nxt;
    logic               w_game_over_nxt;
    logic [CNT_W-1:0]   w_invuln_cnt_nxt;

    assign w_frame_edge = vsync_in & ~r_vsync_d;

    // Box test of the currently indexed snapshot missile, widened so sums cannot wrap
    assign w_mx      = SUM_W'(r_mx[r_idx]);
    assign w_my      = SUM_W'(r_my[r_idx]);
    assign w_sx      = SUM_W'(r_sx);
    assign w_sy      = SUM_W'(r_sy);
    assign w_active  = (w_my < SUM_W'(Y_LIMIT));
    assign w_overlap = (w_mx + SUM_W'(MIS_W) > w_sx) && (w_mx < w_sx + SUM_W'(SHIP_W)) &&
                       (w_my + SUM_W'(MIS_H) > w_sy) && (w_my < w_sy + SUM_W'(SHIP_H));
    assign w_mis_hit = w_active && w_overlap;

    assign w_accept = r_hit_flag && (r_invuln_cnt == '0) && (r_lives != '0);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_frame_edge) w_state_nxt = S_SCAN;
                S_SCAN:    if (r_idx == 3'(N_MIS - 1)) w_state_nxt = S_RESOLVE;
                S_RESOLVE: w_state_nxt = (w_accept && r_lives == 3'd1) ? S_DEAD : S_IDLE;
                S_DEAD:    w_state_nxt = S_DEAD;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_lives_nxt      = r_lives;
        w_hit_nxt        = 1'b0;
        w_game_over_nxt  = r_game_over;
        w_invuln_cnt_nxt = r_invuln_cnt;
        if (new_game) begin
            w_lives_nxt      = 3'(LIVES_INIT);
            w_game_over_nxt  = 1'b0;
            w_invuln_cnt_nxt = '0;
        end else if (r_state == S_RESOLVE) begin
            if (w_accept) begin
                w_lives_nxt      = r_lives - 3'd1;
                w_hit_nxt        = 1'b1;
                w_invuln_cnt_nxt = CNT_W'(INVULN_FRAMES);
                if (r_lives == 3'd1) w_game_over_nxt = 1'b1;
            end else if (r_invuln_cnt != '0) begin
                w_invuln_cnt_nxt = r_invuln_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_lives      <= 3'(LIVES_INIT);
            r_hit        <= 1'b0;
            r_game_over  <= 1'b0;
            r_invuln_cnt <= '0;
            r_invuln     <= 1'b0;
        end else begin
            r_lives      <= w_lives_nxt;
            r_hit        <= w_hit_nxt;
            r_game_over  <= w_game_over_nxt;
            r_invuln_cnt <= w_invuln_cnt_nxt;
            r_invuln     <= (w_invuln_cnt_nxt != '0);
        end
    end

    // Frame snapshot and sequential scan accumulator
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_vsync_d  <= 1'b0;
            r_sx       <= '0;
            r_sy       <= '0;
            for (int i = 0; i < N_MIS; i++) begin
                r_mx[i] <= '0;
                r_my[i] <= '0;
            end
            r_idx      <= '0;
            r_hit_flag <= 1'b0;
        end else begin
            r_vsync_d <= vsync_in;
            if (!new_game) begin
                if (r_state == S_IDLE && w_frame_edge) begin
                    r_sx       <= xpos_ship;
                    r_sy       <= ypos_ship;
                    r_mx[0]    <= en1_x_missile;
                    r_mx[1]    <= en2_x_missile;
                    r_mx[2]    <= en3_x_missile;
                    r_mx[3]    <= en4_x_missile;
                    r_mx[4]    <= en5_x_missile;
                    r_my[0]    <= en1_y_missile;
                    r_my[1]    <= en2_y_missile;
                    r_my[2]    <= en3_y_missile;
                    r_my[3]    <= en4_y_missile;
                    r_my[4]    <= en5_y_missile;
                    r_idx      <= '0;
                    r_hit_flag <= 1'b0;
                end else if (r_state == S_SCAN) begin
                    r_hit_flag <= r_hit_flag | w_mis_hit;
                    r_idx      <= r_idx + 3'd1;
                end
            end
        end
    end

    assign lives     = r_lives;
    assign hit       = r_hit;
    assign invuln    = r_invuln;
    assign game_over = r_game_over;

endmodule
